// File: rtl/alu_operand_sequencer_if.sv
// ============================================================================
// alu_operand_sequencer_if : switch inputs and operand outputs of the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_operand_sequencer_if #(
  parameter int NBITS_OP = 3,
  parameter int NBITS_FN = 2
) ();
  logic [NBITS_OP-1:0] swi_data;
  logic                swi_enter;
  logic                swi_clear;
  logic [NBITS_OP-1:0] op_a;
  logic [NBITS_OP-1:0] op_b;
  logic [NBITS_FN-1:0] op_f;
  logic                op_valid;
  logic [1:0]          seq_state;
  logic                enter_pulse;

  modport master (
    input  swi_data, swi_enter, swi_clear,
    output op_a, op_b, op_f, op_valid, seq_state, enter_pulse
  );

  modport slave (
    output swi_data, swi_enter, swi_clear,
    input  op_a, op_b, op_f, op_valid, seq_state, enter_pulse
  );
endinterface

`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
// ============================================================================
// alu_operand_sequencer : enters A, B, F from shared switches on debounced enter
// Option macro OPSEQ_LIVE_FN_EN: op_f follows the switches while in RUN.
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int NBITS_OP        = 3,
  parameter int NBITS_FN        = 2
) (
  input  wire logic              clk_2,
  input  wire logic              rst_n,
  alu_operand_sequencer_if.master bus
);

  localparam int c_cnt_w = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_A   = 2'd0,
    ST_B   = 2'd1,
    ST_F   = 2'd2,
    ST_RUN = 2'd3
  } state_t;

  logic               r_enter_meta, r_enter_sync;
  logic               r_clear_meta, r_clear_sync;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_deb, r_deb_q;
  logic               w_enter_pulse;

  state_t              r_state, w_state_nxt;
  logic [NBITS_OP-1:0] r_op_a, w_op_a_nxt;
  logic [NBITS_OP-1:0] r_op_b, w_op_b_nxt;
  logic [NBITS_FN-1:0] r_op_f, w_op_f_nxt;
  logic                r_op_valid, w_op_valid_nxt;

  // Synchronisers and enter debouncer; keeps running through clear
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_enter_meta <= 1'b0;
      r_enter_sync <= 1'b0;
      r_clear_meta <= 1'b0;
      r_clear_sync <= 1'b0;
      r_cnt        <= '0;
      r_deb        <= 1'b0;
      r_deb_q      <= 1'b0;
    end else begin
      r_enter_meta <= bus.swi_enter;
      r_enter_sync <= r_enter_meta;
      r_clear_meta <= bus.swi_clear;
      r_clear_sync <= r_clear_meta;
      r_deb_q      <= r_deb;
      if (r_enter_sync == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_deb <= r_enter_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign w_enter_pulse = r_deb & ~r_deb_q;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_A;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_f     <= '0;
      r_op_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op_a     <= w_op_a_nxt;
      r_op_b     <= w_op_b_nxt;
      r_op_f     <= w_op_f_nxt;
      r_op_valid <= w_op_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_op_a_nxt     = r_op_a;
    w_op_b_nxt     = r_op_b;
    w_op_f_nxt     = r_op_f;
    w_op_valid_nxt = r_op_valid;
    // Clear wins over a coincident enter pulse, which is simply dropped
    if (r_clear_sync) begin
      w_state_nxt    = ST_A;
      w_op_a_nxt     = '0;
      w_op_b_nxt     = '0;
      w_op_f_nxt     = '0;
      w_op_valid_nxt = 1'b0;
    end else begin
`ifdef OPSEQ_LIVE_FN_EN
      if (r_state == ST_RUN) begin
        w_op_f_nxt = bus.swi_data[NBITS_FN-1:0];
      end
`else
`endif
      if (w_enter_pulse) begin
        unique case (r_state)
          ST_A: begin
            w_op_a_nxt  = bus.swi_data;
            w_state_nxt = ST_B;
          end
          ST_B: begin
            w_op_b_nxt  = bus.swi_data;
            w_state_nxt = ST_F;
          end
          ST_F: begin
            w_op_f_nxt     = bus.swi_data[NBITS_FN-1:0];
            w_op_valid_nxt = 1'b1;
            w_state_nxt    = ST_RUN;
          end
          ST_RUN: begin
            w_op_valid_nxt = 1'b0;
            w_state_nxt    = ST_A;
          end
          default: w_state_nxt = ST_A;
        endcase
      end
    end
  end

  assign bus.op_a        = r_op_a;
  assign bus.op_b        = r_op_b;
  assign bus.op_f        = r_op_f;
  assign bus.op_valid    = r_op_valid;
  assign bus.seq_state   = r_state;
  assign bus.enter_pulse = w_enter_pulse;

endmodule

`default_nettype wire
